media_cmd_arbiter: RTL and testbench
====================================

Name: media_cmd_arbiter

Overview:
- Sequencer and arbiter for the car-audio volume/song control state.
- Two command sources share the control state:
  - Bluetooth UART byte stream: ASCII '1' to '4'.
  - Four debounced on-board buttons.
- Grants one command at a time, applies it to the saturating volume and wrapping song index, then enforces a hold-off window before the next grant.
- Sits between the UART receiver / button debouncer and the audio player / display.

Parameters:
- HOLDOFF_CYC, default 50000000: cycles of lock-out after each applied command; must be >= 1.
- VOL_MAX, default 3: top volume level (<= 3); bottom is 0.
- SONG_MAX, default 7: highest song index (<= 15); lowest is 1.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous, active-low reset.
- bt_data  in  8: byte from the UART receiver.
- bt_valid  in  1: one-cycle strobe qualifying bt_data.
- btn_req  in  4: one-cycle pulses. [0] vol up, [1] vol down, [2] song prev, [3] song next.
- vol  out  2: current volume level.
- song  out  4: current song index.
- upd  out  1: one-cycle pulse when vol or song changed value.
- busy  out  1: high while in HOLD.
- drop  out  1: one-cycle pulse when a valid request is discarded.

Behaviour:
- Reset (async, rst_n=0): state IDLE, vol=VOL_MAX, song=1, upd=0, busy=0, drop=0, holdoff counter=0, last_grant=BTN (so BT wins the first tie).
- Decode:
  - BT: 0x31 vol up, 0x32 vol down, 0x33 prev, 0x34 next. Other bytes are ignored: not a request, no drop.
  - Buttons: with several bits set, the lowest index wins. The other bits are discarded silently.
- FSM: IDLE, APPLY, HOLD.
- IDLE:
  - A valid request from exactly one source latches that command and goes to APPLY next cycle.
  - Both sources valid in the same cycle: the source that did not win last_grant is granted; last_grant is updated; the loser is discarded and drop pulses next cycle.
- APPLY (exactly 1 cycle): update vol/song at the end of the cycle, load counter=HOLDOFF_CYC-1, go to HOLD.
  - upd=1 in the same cycle the new value first appears, and only if the value actually changed.
- HOLD:
  - busy=1; the counter decrements each cycle; at counter==0, go to IDLE next cycle.
  - Any valid request arriving in APPLY or HOLD is discarded; drop pulses next cycle (one pulse even if both sources request in that cycle).
- Latency: request sampled in cycle N.
  - New vol/song and upd are visible in cycle N+2.
  - busy is high for cycles N+2 .. N+1+HOLDOFF_CYC.
  - Next grant is possible at cycle N+2+HOLDOFF_CYC.
- Volume saturates at both ends:
  - Up at VOL_MAX: no change, upd=0, HOLD still entered.
  - Down at 0: no change, upd=0, HOLD still entered.
- Song wraps within 1..SONG_MAX: next at SONG_MAX gives 1; prev at 1 gives SONG_MAX. Song 0 never occurs.
- Reset asserted mid-APPLY or mid-HOLD aborts immediately to the reset values. The pending command is lost.
- upd and drop are registered. They are never high for more than one cycle per event.

Optional Feature:
- Macro MEDIA_MUTE_EN.
- Defined:
  - Extra output port "mute out 1", reset 0.
  - BT byte 0x35 is a command: it toggles mute through the normal APPLY/HOLD path, and upd=1 on every toggle.
  - While mute=1, vol reads 0, but the internal level is retained.
  - vol up/down while muted clears mute, applies the step to the internal level, and pulses upd.
- Undefined: no mute port; 0x35 is ignored like any other unknown byte.

Test Plan (HOLDOFF_CYC=8, VOL_MAX=3, SONG_MAX=7):
- Reset release, then BT 0x32 at cycle N: vol 3 to 2 and upd=1 at N+2; busy high for cycles N+2 .. N+9; a second 0x32 at N+5 gives drop=1 at N+6 and vol stays 2.
- btn_req=0001 while vol=3: no vol change, upd stays 0, busy still asserted for 8 cycles.
- BT 0x34 and btn_req=0100 in the same cycle from reset: BT granted (song 1 to 2), drop=1. Repeat the tie after HOLD: the button is granted (song 2 to 1).
- Song wrap: from song=7, next gives 1; then prev gives 7; upd=1 each time.
- BT 0x41 in IDLE: no state change, no drop, no upd. Then rst_n low during HOLD: all outputs return to reset values in the same cycle (async).
- MEDIA_MUTE_EN build:
  - 0x35 gives mute=1, vol reads 0, upd=1.
  - Then 0x31 gives mute=0, vol=3 (saturated from internal 3), upd=1.

Source files
------------

// File: rtl/media_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// media_cmd_arbiter
//   Arbitrates volume/song commands from a Bluetooth UART byte stream and four
//   debounced buttons. It grants one command at a time and applies it to a
//   saturating volume level and a wrapping song index. After each applied
//   command it locks out new requests for HOLDOFF_CYC cycles.
//
// Parameters
//   HOLDOFF_CYC : lock-out cycles after each applied command (>= 1)
//   VOL_MAX     : top volume level (<= 3), bottom is 0
//   SONG_MAX    : highest song index (<= 15), lowest is 1
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   bt_data  in   [7:0] byte from the UART receiver ('1'..'4' are commands)
//   bt_valid in   one-cycle strobe qualifying bt_data
//   btn_req  in   [3:0] button pulses: 0 vol up, 1 vol down, 2 prev, 3 next
//   vol      out  [1:0] current volume level
//   song     out  [3:0] current song index
//   upd      out  one-cycle pulse when vol/song (or mute) changed value
//   busy     out  high while in the hold-off window
//   drop     out  one-cycle pulse when a valid request was discarded
//   mute     out  mute state (only when MEDIA_MUTE_EN is defined)
//
// Optional feature macro: MEDIA_MUTE_EN
//   Adds the mute port and makes BT byte 0x35 a mute toggle. While muted, vol
//   reads 0 but the internal level is kept; vol up/down clears mute.
// -----------------------------------------------------------------------------
module media_cmd_arbiter #(
  parameter int HOLDOFF_CYC = 50000000,
  parameter int VOL_MAX     = 3,
  parameter int SONG_MAX    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bt_data,
  input  logic       bt_valid,
  input  logic [3:0] btn_req,
  output logic [1:0] vol,
  output logic [3:0] song,
  output logic       upd,
  output logic       busy,
  output logic       drop
`ifdef MEDIA_MUTE_EN
  ,
  output logic       mute
`endif
);

  localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [1:0] VOL_TOP  = 2'(VOL_MAX);
  localparam logic [3:0] SONG_TOP = 4'(SONG_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_VUP  = 3'd0,
    CMD_VDN  = 3'd1,
    CMD_PREV = 3'd2,
    CMD_NEXT = 3'd3,
    CMD_MUTE = 3'd4
  } cmd_t;

  // last_grant encoding: which source won the most recent grant
  localparam logic GRANT_BT  = 1'b0;
  localparam logic GRANT_BTN = 1'b1;

  state_t           state_r;
  cmd_t             cmd_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       level_r;
  logic [1:0]       vol_r;
  logic [3:0]       song_r;
  logic             mute_r;
  logic             upd_r;
  logic             busy_r;
  logic             drop_r;
  logic             last_grant_r;

  logic             bt_req_s;
  cmd_t             bt_cmd_s;
  logic             btn_req_s;
  cmd_t             btn_cmd_s;
  logic             any_req_s;
  logic [1:0]       level_nx_s;
  logic [3:0]       song_nx_s;
  logic             mute_nx_s;
  logic [1:0]       vol_nx_s;
  logic             upd_nx_s;

  // Decode the BT byte into a command; unknown bytes are not requests.
  always_comb begin
    bt_req_s = 1'b0;
    bt_cmd_s = CMD_VUP;
    if (bt_valid) begin
      case (bt_data)
        8'h31: begin bt_req_s = 1'b1; bt_cmd_s = CMD_VUP;  end
        8'h32: begin bt_req_s = 1'b1; bt_cmd_s = CMD_VDN;  end
        8'h33: begin bt_req_s = 1'b1; bt_cmd_s = CMD_PREV; end
        8'h34: begin bt_req_s = 1'b1; bt_cmd_s = CMD_NEXT; end
`ifdef MEDIA_MUTE_EN
        8'h35: begin bt_req_s = 1'b1; bt_cmd_s = CMD_MUTE; end
`endif
        default: begin bt_req_s = 1'b0; bt_cmd_s = CMD_VUP; end
      endcase
    end else begin
      bt_req_s = 1'b0;
    end
  end

  // Decode buttons; the lowest set bit wins and the rest vanish silently.
  always_comb begin
    btn_req_s = 1'b1;
    btn_cmd_s = CMD_VUP;
    if (btn_req[0]) begin
      btn_cmd_s = CMD_VUP;
    end else if (btn_req[1]) begin
      btn_cmd_s = CMD_VDN;
    end else if (btn_req[2]) begin
      btn_cmd_s = CMD_PREV;
    end else if (btn_req[3]) begin
      btn_cmd_s = CMD_NEXT;
    end else begin
      btn_req_s = 1'b0;
    end
  end

  assign any_req_s = bt_req_s | btn_req_s;

  // Next control values for the latched command (used only in APPLY).
  always_comb begin
    level_nx_s = level_r;
    song_nx_s  = song_r;
    mute_nx_s  = mute_r;
    case (cmd_r)
      CMD_VUP: begin
        mute_nx_s = 1'b0;
        if (level_r < VOL_TOP) level_nx_s = level_r + 2'd1;
        else                   level_nx_s = level_r;
      end
      CMD_VDN: begin
        mute_nx_s = 1'b0;
        if (level_r != 2'd0) level_nx_s = level_r - 2'd1;
        else                 level_nx_s = level_r;
      end
      CMD_PREV: begin
        if (song_r <= 4'd1) song_nx_s = SONG_TOP;
        else                song_nx_s = song_r - 4'd1;
      end
      CMD_NEXT: begin
        if (song_r >= SONG_TOP) song_nx_s = 4'd1;
        else                    song_nx_s = song_r + 4'd1;
      end
      CMD_MUTE: begin
        mute_nx_s = ~mute_r;
      end
      default: begin
        level_nx_s = level_r;
      end
    endcase
    vol_nx_s = mute_nx_s ? 2'd0 : level_nx_s;
    // A mute toggle always counts as a change, so upd fires on every toggle.
    upd_nx_s = (level_nx_s != level_r) || (song_nx_s != song_r) ||
               (mute_nx_s != mute_r);
  end

  // Arbitration FSM with registered outputs and hold-off counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cmd_r        <= CMD_VUP;
      cnt_r        <= '0;
      level_r      <= VOL_TOP;
      vol_r        <= VOL_TOP;
      song_r       <= 4'd1;
      mute_r       <= 1'b0;
      upd_r        <= 1'b0;
      busy_r       <= 1'b0;
      drop_r       <= 1'b0;
      last_grant_r <= GRANT_BTN;
    end else begin
      upd_r  <= 1'b0;
      drop_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bt_req_s && btn_req_s) begin
            // Tie: the source that did not win last time gets the grant.
            state_r <= ST_APPLY;
            drop_r  <= 1'b1;
            if (last_grant_r == GRANT_BTN) begin
              cmd_r        <= bt_cmd_s;
              last_grant_r <= GRANT_BT;
            end else begin
              cmd_r        <= btn_cmd_s;
              last_grant_r <= GRANT_BTN;
            end
          end else if (bt_req_s) begin
            state_r      <= ST_APPLY;
            cmd_r        <= bt_cmd_s;
            last_grant_r <= GRANT_BT;
          end else if (btn_req_s) begin
            state_r      <= ST_APPLY;
            cmd_r        <= btn_cmd_s;
            last_grant_r <= GRANT_BTN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          level_r <= level_nx_s;
          song_r  <= song_nx_s;
          mute_r  <= mute_nx_s;
          vol_r   <= vol_nx_s;
          upd_r   <= upd_nx_s;
          cnt_r   <= CNT_LOAD;
          busy_r  <= 1'b1;
          drop_r  <= any_req_s;
          state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          drop_r <= any_req_s;
          if (cnt_r == '0) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign vol  = vol_r;
  assign song = song_r;
  assign upd  = upd_r;
  assign busy = busy_r;
  assign drop = drop_r;
`ifdef MEDIA_MUTE_EN
  assign mute = mute_r;
`endif

endmodule

// File: tb/tb_media_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_media_cmd_arbiter
//   Directed testbench for media_cmd_arbiter with HOLDOFF_CYC=8, VOL_MAX=3,
//   SONG_MAX=7. Inputs are driven 1 ns after the rising edge and outputs are
//   checked at that same point, well away from the next active edge.
//   Define MEDIA_MUTE_EN to exercise the mute build.
// -----------------------------------------------------------------------------
module tb_media_cmd_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] bt_data;
  logic       bt_valid;
  logic [3:0] btn_req;
  logic [1:0] vol;
  logic [3:0] song;
  logic       upd;
  logic       busy;
  logic       drop;
`ifdef MEDIA_MUTE_EN
  logic       mute;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  media_cmd_arbiter #(
    .HOLDOFF_CYC (8),
    .VOL_MAX     (3),
    .SONG_MAX    (7)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bt_data  (bt_data),
    .bt_valid (bt_valid),
    .btn_req  (btn_req),
    .vol      (vol),
    .song     (song),
    .upd      (upd),
    .busy     (busy),
    .drop     (drop)
`ifdef MEDIA_MUTE_EN
    ,
    .mute     (mute)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a BT byte in the current cycle N; returns in cycle N+2.
  task automatic send_bt(input logic [7:0] b);
    bt_data  = b;
    bt_valid = 1'b1;
    tick();
    bt_valid = 1'b0;
    bt_data  = 8'h00;
    tick();
  endtask

  // Issue a button pulse in the current cycle N; returns in cycle N+2.
  task automatic send_btn(input logic [3:0] b);
    btn_req = b;
    tick();
    btn_req = 4'b0000;
    tick();
  endtask

  initial begin : stim
    int bc;
    logic any_upd;
    rst_n    = 1'b0;
    bt_data  = 8'h00;
    bt_valid = 1'b0;
    btn_req  = 4'b0000;
    tick();
    tick();

    // Reset values
    check("rst_vol",  32'(vol),  32'd3);
    check("rst_song", 32'(song), 32'd1);
    check("rst_upd",  32'(upd),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
`ifdef MEDIA_MUTE_EN
    check("rst_mute", 32'(mute), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();

    // BT vol down with a second request landing in HOLD
    send_bt(8'h32);                           // cycle N+2
    check("t1_vol",  32'(vol),  32'd2);
    check("t1_upd",  32'(upd),  32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_drop0", 32'(drop), 32'd0);
    tick();                                   // N+3
    check("t1_upd_pulse", 32'(upd), 32'd0);
    tick();
    tick();                                   // N+5
    bt_data  = 8'h32;
    bt_valid = 1'b1;
    tick();                                   // N+6
    bt_valid = 1'b0;
    check("t1_drop", 32'(drop), 32'd1);
    check("t1_vol_kept", 32'(vol), 32'd2);
    tick();                                   // N+7
    check("t1_drop_pulse", 32'(drop), 32'd0);
    check("t1_no_upd", 32'(upd), 32'd0);
    tick();
    tick();                                   // N+9
    check("t1_busy_last", 32'(busy), 32'd1);
    tick();                                   // N+10
    check("t1_busy_end", 32'(busy), 32'd0);

    // Back to vol 3, then button vol up at the top saturates
    send_bt(8'h31);
    check("t2_vol3", 32'(vol), 32'd3);
    check("t2_upd3", 32'(upd), 32'd1);
    run(8);
    send_btn(4'b0001);
    check("t2_sat_vol", 32'(vol), 32'd3);
    bc = 0;
    any_upd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy) bc++;
      any_upd = any_upd | upd;
      tick();
    end
    check("t2_busy_cycles", 32'(bc), 32'd8);
    check("t2_no_upd", 32'(any_upd), 32'd0);
    check("t2_busy_off", 32'(busy), 32'd0);

    // Ties from reset: BT first, then the button
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bt_data  = 8'h34;
    bt_valid = 1'b1;
    btn_req  = 4'b0100;
    tick();
    bt_valid = 1'b0;
    btn_req  = 4'b0000;
    check("t3_drop_a", 32'(drop), 32'd1);
    tick();
    check("t3_song_a", 32'(song), 32'd2);
    check("t3_upd_a",  32'(upd),  32'd1);
    check("t3_drop_a_pulse", 32'(drop), 32'd0);
    run(8);
    bt_data  = 8'h34;
    bt_valid = 1'b1;
    btn_req  = 4'b0100;
    tick();
    bt_valid = 1'b0;
    btn_req  = 4'b0000;
    check("t3_drop_b", 32'(drop), 32'd1);
    tick();
    check("t3_song_b", 32'(song), 32'd1);
    check("t3_upd_b",  32'(upd),  32'd1);
    run(8);

    // Song wrap in both directions
    send_btn(4'b0100);
    check("t4_prev_wrap", 32'(song), 32'd7);
    check("t4_upd_a", 32'(upd), 32'd1);
    run(8);
    send_bt(8'h34);
    check("t4_next_wrap", 32'(song), 32'd1);
    check("t4_upd_b", 32'(upd), 32'd1);
    run(8);
    send_bt(8'h33);
    check("t4_prev_wrap2", 32'(song), 32'd7);
    check("t4_upd_c", 32'(upd), 32'd1);
    run(8);

    // Unknown BT byte is ignored
    bt_data  = 8'h41;
    bt_valid = 1'b1;
    tick();
    bt_valid = 1'b0;
    check("t5_unk_drop", 32'(drop), 32'd0);
    check("t5_unk_busy0", 32'(busy), 32'd0);
    tick();
    check("t5_unk_upd",  32'(upd),  32'd0);
    check("t5_unk_busy", 32'(busy), 32'd0);
    check("t5_unk_song", 32'(song), 32'd7);
    check("t5_unk_vol",  32'(vol),  32'd3);

`ifndef MEDIA_MUTE_EN
    send_bt(8'h35);
    check("t5_35_ignored_busy", 32'(busy), 32'd0);
    check("t5_35_ignored_upd",  32'(upd),  32'd0);
`endif

    // Multiple buttons: lowest index (vol down) wins, no drop
    btn_req = 4'b1010;
    tick();
    btn_req = 4'b0000;
    check("t5_multi_drop", 32'(drop), 32'd0);
    tick();
    check("t5_multi_vol", 32'(vol), 32'd2);
    check("t5_multi_song", 32'(song), 32'd7);
    run(8);

    // Volume down to the bottom and saturate there
    send_bt(8'h32);
    check("t5_vol1", 32'(vol), 32'd1);
    run(8);
    send_bt(8'h32);
    check("t5_vol0", 32'(vol), 32'd0);
    run(8);
    send_bt(8'h32);
    check("t5_sat0_vol",  32'(vol),  32'd0);
    check("t5_sat0_upd",  32'(upd),  32'd0);
    check("t5_sat0_busy", 32'(busy), 32'd1);
    // Both sources request in HOLD: exactly one drop pulse
    bt_data  = 8'h31;
    bt_valid = 1'b1;
    btn_req  = 4'b0001;
    tick();
    bt_valid = 1'b0;
    btn_req  = 4'b0000;
    check("t5_hold_drop", 32'(drop), 32'd1);
    tick();
    check("t5_hold_drop_pulse", 32'(drop), 32'd0);
    check("t5_hold_vol", 32'(vol), 32'd0);
    run(6);

    // Async reset in the middle of HOLD
    send_bt(8'h31);
    check("t6_vol1", 32'(vol), 32'd1);
    check("t6_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_vol",  32'(vol),  32'd3);
    check("t6_arst_song", 32'(song), 32'd1);
    check("t6_arst_upd",  32'(upd),  32'd0);
    check("t6_arst_busy", 32'(busy), 32'd0);
    check("t6_arst_drop", 32'(drop), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

`ifdef MEDIA_MUTE_EN
    // Mute toggle, then vol up clears mute
    send_bt(8'h35);
    check("t7_mute_on",  32'(mute), 32'd1);
    check("t7_mute_vol", 32'(vol),  32'd0);
    check("t7_mute_upd", 32'(upd),  32'd1);
    run(8);
    send_bt(8'h31);
    check("t7_unmute",     32'(mute), 32'd0);
    check("t7_unmute_vol", 32'(vol),  32'd3);
    check("t7_unmute_upd", 32'(upd),  32'd1);
    run(8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
